// File: rtl/ndp_pkg.sv
// Shared types and width helpers for the NDP stream controller.
// Sizes are derived from the systolic array geometry.
package ndp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_WAIT,
      S_DRAIN
   } state_t;

   localparam logic [1:0] SIMD_16B = 2'd0;
   localparam logic [1:0] SIMD_8B  = 2'd1;
   localparam logic [1:0] SIMD_4B  = 2'd2;
   localparam logic [1:0] SIMD_2B  = 2'd3;

   function automatic int calc_a_w(int h, int sh, int w);
      return h * sh * w;
   endfunction

   function automatic int calc_b_w(int aw, int sw, int w);
      return aw * sw * w;
   endfunction

   function automatic int calc_rows(int h, int sh);
      return h * sh;
   endfunction

   function automatic int calc_sel_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ndp_row_mux.sv
// Picks one output row out of the flattened result matrix.
// Out-of-range selects return zero.
module ndp_row_mux
   import ndp_pkg::*;
#(
   parameter int N_ROWS = 4,
   parameter int ROW_W  = 64,
   parameter int SEL_W  = 2
) (
   input  logic [N_ROWS*ROW_W-1:0] data,
   input  logic [SEL_W-1:0]        sel,
   output logic [ROW_W-1:0]        row
);

   // Row selection by index
   always_comb begin
      row = '0;
      for (int i = 0; i < N_ROWS; i++) begin
         if (sel == SEL_W'(i)) begin
            row = data[i*ROW_W +: ROW_W];
         end
      end
   end

endmodule

// File: rtl/ndp_stream_ctrl.sv
// Job controller feeding operands into the NDP unit
// and draining its result matrix row by row.
module ndp_stream_ctrl
   import ndp_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ARR_WIDTH  = 4,
   parameter int ARR_HEIGHT = 4,
   parameter int SYS_WIDTH  = 64,
   parameter int SYS_HEIGHT = 1,
   parameter int K_BITS     = 16,
   localparam int A_W    = calc_a_w(ARR_HEIGHT, SYS_HEIGHT, WIDTH),
   localparam int B_W    = calc_b_w(ARR_WIDTH, SYS_WIDTH, WIDTH),
   localparam int N_ROWS = calc_rows(ARR_HEIGHT, SYS_HEIGHT),
   localparam int ROW_W  = B_W,
   localparam int C_W    = N_ROWS * ROW_W,
   localparam int RW     = calc_sel_w(N_ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [K_BITS-1:0] cmd_k,
   input  logic [1:0]        cmd_simd,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [A_W-1:0]    op_a,
   input  logic [B_W-1:0]    op_b,
   output logic [A_W-1:0]    ndp_in_a,
   output logic [B_W-1:0]    ndp_in_b,
   output logic              ndp_in_done_flag,
   output logic [1:0]        ndp_simd,
   output logic              ndp_clear,
   input  logic              ndp_calc_done_flag,
   input  logic [C_W-1:0]    ndp_out_c,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ROW_W-1:0]  res_data,
   output logic [RW-1:0]     res_row,
   output logic              res_last,
   output logic              busy
);

   localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

   state_t            state;
   logic [K_BITS-1:0] kcnt;
   logic [RW-1:0]     r;
   logic [ROW_W-1:0]  row_sel;

   ndp_row_mux #(
      .N_ROWS (N_ROWS),
      .ROW_W  (ROW_W),
      .SEL_W  (RW)
   ) u_row_mux (
      .data (ndp_out_c),
      .sel  (r),
      .row  (row_sel)
   );

   assign res_row  = r;
   assign res_data = res_valid ? row_sel : '0;
   assign res_last = res_valid && (r == LAST_ROW);

   // Job sequencing with all handshake outputs registered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         kcnt             <= '0;
         r                <= '0;
         ndp_in_a         <= '0;
         ndp_in_b         <= '0;
         ndp_in_done_flag <= 1'b0;
         ndp_simd         <= '0;
         ndp_clear        <= 1'b0;
         cmd_ready        <= 1'b1;
         op_ready         <= 1'b0;
         res_valid        <= 1'b0;
         busy             <= 1'b0;
      end else begin
         ndp_clear <= 1'b0;
         ndp_in_a  <= '0;
         ndp_in_b  <= '0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  kcnt      <= cmd_k;
                  ndp_simd  <= cmd_simd;
                  ndp_clear <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (kcnt != '0) begin
                  op_ready <= 1'b1;
                  state    <= S_FEED;
               end else begin
                  state    <= S_WAIT;
               end
            end
            S_FEED: begin
               if (op_valid) begin
                  ndp_in_a <= op_a;
                  ndp_in_b <= op_b;
                  kcnt     <= kcnt - K_BITS'(1);
                  if (kcnt == K_BITS'(1)) begin
                     op_ready <= 1'b0;
                     state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               ndp_in_done_flag <= 1'b1;
               if (ndp_calc_done_flag) begin
                  r         <= '0;
                  res_valid <= 1'b1;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (res_ready) begin
                  if (r == LAST_ROW) begin
                     r                <= '0;
                     res_valid        <= 1'b0;
                     ndp_in_done_flag <= 1'b0;
                     cmd_ready        <= 1'b1;
                     busy             <= 1'b0;
                     state            <= S_IDLE;
                  end else begin
                     r <= r + RW'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
